// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multi-cycle ARM-style control FSM.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        DP_EXEC   = 4'd2,
        DP_WB     = 4'd3,
        MEM_ADDR  = 4'd4,
        MEM_READ  = 4'd5,
        MEM_WB    = 4'd6,
        MEM_WRITE = 4'd7,
        BRANCH    = 4'd8
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] BSEL_B     = 2'b00;
    localparam logic [1:0] BSEL_ONE   = 2'b01;
    localparam logic [1:0] BSEL_IMM12 = 2'b10;
    localparam logic [1:0] BSEL_IMM26 = 2'b11;

    localparam logic [1:0] DTI_MDR = 2'b00;
    localparam logic [1:0] DTI_ALU = 2'b01;
    localparam logic [1:0] DTI_PC  = 2'b10;

    localparam logic [1:0] IT_DP    = 2'b00;
    localparam logic [1:0] IT_MEM   = 2'b01;
    localparam logic [1:0] IT_BR    = 2'b10;
    localparam logic [1:0] IT_UNDEF = 2'b11;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;

    typedef struct packed {
        logic       pc_write;
        logic       ior_d;
        logic       mem_write;
        logic       mem_read;
        logic       ir_write;
        logic       dpi;
        logic       blink;
        logic       write_reg;
        logic       alu_a_sel;
        logic       ld;
        logic       en;
        logic       pc_src;
        logic [1:0] dti;
        logic [1:0] alu_b_sel;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, strobes and selects out.
interface multicycle_controller_if;
    logic [3:0] cond;
    logic [1:0] instType;
    logic       immBit;
    logic [3:0] opcode;
    logic       sBit;
    logic       linkBit;
    logic       ZEro, carry, negative, overflow;

    logic       pcWrite, IorD, MemWrite, MemRead, IRWrite, DPI, BLink, WriteReg;
    logic       ALUASel, ld, en, PCSrc;
    logic [1:0] DTI, ALUBSel, ALUop;

    modport master (
        input  cond, instType, immBit, opcode, sBit, linkBit,
        input  ZEro, carry, negative, overflow,
        output pcWrite, IorD, MemWrite, MemRead, IRWrite, DPI, BLink, WriteReg,
        output ALUASel, ld, en, PCSrc, DTI, ALUBSel, ALUop
    );

    modport slave (
        output cond, instType, immBit, opcode, sBit, linkBit,
        output ZEro, carry, negative, overflow,
        input  pcWrite, IorD, MemWrite, MemRead, IRWrite, DPI, BLink, WriteReg,
        input  ALUASel, ld, en, PCSrc, DTI, ALUBSel, ALUop
    );
endinterface

// File: rtl/multicycle_controller_cond_check.sv
// Combinational ARM condition-code evaluation against the registered flags.
module multicycle_controller_cond_check (
    input  logic [3:0] cond,
    input  logic       z,
    input  logic       c,
    input  logic       n,
    input  logic       v,
    output logic       pass
);
    always_comb begin
        pass = 1'b0;
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = !z;
            4'b0010: pass = c;
            4'b0011: pass = !c;
            4'b0100: pass = n;
            4'b0101: pass = !n;
            4'b0110: pass = v;
            4'b0111: pass = !v;
            4'b1000: pass = c & !z;
            4'b1001: pass = !c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = !z & (n == v);
            4'b1101: pass = z | (n != v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle datapath: strobe decode, sequencing and retire counter.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus,
    output logic [3:0]              state_o,
    output logic [RETIRE_W-1:0]     retired,
    output logic                    instrDone
);
    state_t              state_q, state_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    ctrl_t               ctrl;
    logic                done;
    logic                cond_pass;
    logic                is_add, is_sub, is_cmp, is_and, is_orr, is_mapped, set_flags;

    multicycle_controller_cond_check u_cond_check (
        .cond (bus.cond),
        .z    (bus.ZEro),
        .c    (bus.carry),
        .n    (bus.negative),
        .v    (bus.overflow),
        .pass (cond_pass)
    );

    assign is_add    = (bus.opcode == OP_ADD);
    assign is_sub    = (bus.opcode == OP_SUB);
    assign is_cmp    = (bus.opcode == OP_CMP);
    assign is_and    = (bus.opcode == OP_AND);
    assign is_orr    = (bus.opcode == OP_ORR);
    assign is_mapped = is_add | is_sub | is_cmp | is_and | is_orr;
    assign set_flags = bus.sBit | is_cmp;

    always_comb begin
        ctrl    = '0;
        done    = 1'b0;
        state_d = FETCH;
        case (state_q)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_b_sel = BSEL_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_write  = 1'b1;
                state_d        = DECODE;
            end
            DECODE: begin
                // Branch target is computed speculatively here for BRANCH to use.
                ctrl.alu_b_sel = BSEL_IMM26;
                if (!cond_pass || bus.instType == IT_UNDEF) begin
                    done = 1'b1;
                end else if (bus.instType == IT_DP) begin
                    state_d = DP_EXEC;
                end else if (bus.instType == IT_MEM) begin
                    state_d = MEM_ADDR;
                end else begin
                    state_d = BRANCH;
                end
            end
            DP_EXEC: begin
                ctrl.alu_a_sel = 1'b1;
                ctrl.alu_b_sel = bus.immBit ? BSEL_IMM12 : BSEL_B;
                if (is_sub || is_cmp) ctrl.alu_op = ALU_SUB;
                else if (is_and)      ctrl.alu_op = ALU_AND;
                else if (is_orr)      ctrl.alu_op = ALU_ORR;
                else                  ctrl.alu_op = ALU_ADD;
                // Unmapped opcodes retire as NOPs, so they must not touch the flags either.
                ctrl.ld = set_flags & is_mapped;
                ctrl.en = set_flags & (is_add | is_sub | is_cmp);
                if (is_cmp || !is_mapped) done = 1'b1;
                else                      state_d = DP_WB;
            end
            DP_WB: begin
                ctrl.write_reg = 1'b1;
                ctrl.dti       = DTI_ALU;
                done           = 1'b1;
            end
            MEM_ADDR: begin
                ctrl.alu_a_sel = 1'b1;
                ctrl.alu_b_sel = BSEL_IMM12;
                ctrl.alu_op    = ALU_ADD;
                ctrl.dpi       = !bus.sBit;
                state_d        = bus.sBit ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                ctrl.ior_d    = 1'b1;
                ctrl.mem_read = 1'b1;
                state_d       = MEM_WB;
            end
            MEM_WB: begin
                ctrl.write_reg = 1'b1;
                ctrl.dti       = DTI_MDR;
                done           = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.ior_d     = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.dpi       = 1'b1;
                done           = 1'b1;
            end
            BRANCH: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = 1'b1;
                if (bus.linkBit) begin
                    ctrl.write_reg = 1'b1;
                    ctrl.blink     = 1'b1;
                    ctrl.dti       = DTI_PC;
                end
                done = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        // Reset silences everything immediately, even mid-instruction.
        if (!rst) begin
            ctrl = '0;
            done = 1'b0;
        end
    end

    assign retired_d = retired_q + RETIRE_W'(done);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign bus.pcWrite  = ctrl.pc_write;
    assign bus.IorD     = ctrl.ior_d;
    assign bus.MemWrite = ctrl.mem_write;
    assign bus.MemRead  = ctrl.mem_read;
    assign bus.IRWrite  = ctrl.ir_write;
    assign bus.DPI      = ctrl.dpi;
    assign bus.BLink    = ctrl.blink;
    assign bus.WriteReg = ctrl.write_reg;
    assign bus.ALUASel  = ctrl.alu_a_sel;
    assign bus.ld       = ctrl.ld;
    assign bus.en       = ctrl.en;
    assign bus.PCSrc    = ctrl.pc_src;
    assign bus.DTI      = ctrl.dti;
    assign bus.ALUBSel  = ctrl.alu_b_sel;
    assign bus.ALUop    = ctrl.alu_op;

    assign state_o   = rst ? state_q : 4'd0;
    assign retired   = rst ? retired_q : '0;
    assign instrDone = done;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions against a trace-level model.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    state_o;
    logic [RW-1:0] retired;
    logic          instrDone;

    int n_asserts = 0;
    int n_fail    = 0;
    int exp_retired = 0;

    // Each entry: {state[3:0], strobes[17:0], instrDone}
    logic [22:0] exp_q[$];

    multicycle_controller_if bus ();

    multicycle_controller #(.RETIRE_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_o   (state_o),
        .retired   (retired),
        .instrDone (instrDone)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] sig(
        input logic pcw, iord, mw, mr, irw, dpi, bl, wr, asel, ld, en, pcs,
        input logic [1:0] dti, bsel, aop);
        return {pcw, iord, mw, mr, irw, dpi, bl, wr, asel, ld, en, pcs, dti, bsel, aop};
    endfunction

    function automatic logic [17:0] observed_sig();
        return {bus.pcWrite, bus.IorD, bus.MemWrite, bus.MemRead, bus.IRWrite, bus.DPI,
                bus.BLink, bus.WriteReg, bus.ALUASel, bus.ld, bus.en, bus.PCSrc,
                bus.DTI, bus.ALUBSel, bus.ALUop};
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic z, cy, n, v);
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void push(input state_t st, input logic [17:0] s, input logic d);
        exp_q.push_back({4'(st), s, d});
    endfunction

    // Build the full expected cycle trace of one instruction from the ISA rules.
    function automatic void build_trace(
        input logic [3:0] c, input logic [1:0] it, input logic imm, input logic [3:0] op,
        input logic s, input logic lnk, input logic [3:0] flags);
        logic       known, arith, cmp, fl;
        logic [1:0] aop;
        push(FETCH, sig(1,0,0,1,1,0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b00), 1'b0);
        if (!cond_ok(c, flags[3], flags[2], flags[1], flags[0]) || it == 2'b11) begin
            push(DECODE, sig(0,0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b00), 1'b1);
            return;
        end
        push(DECODE, sig(0,0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b00), 1'b0);
        if (it == 2'b00) begin
            known = 1'b1; arith = 1'b0; cmp = 1'b0; aop = 2'b00;
            case (op)
                4'b0100: begin aop = 2'b00; arith = 1'b1; end
                4'b0010: begin aop = 2'b01; arith = 1'b1; end
                4'b1010: begin aop = 2'b01; arith = 1'b1; cmp = 1'b1; end
                4'b0000: aop = 2'b10;
                4'b1100: aop = 2'b11;
                default: known = 1'b0;
            endcase
            fl = s || cmp;
            push(DP_EXEC, sig(0,0,0,0,0,0,0,0,1, fl && known, fl && arith, 0,
                              2'b00, imm ? 2'b10 : 2'b00, aop), cmp || !known);
            if (known && !cmp)
                push(DP_WB, sig(0,0,0,0,0,0,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00), 1'b1);
        end else if (it == 2'b01) begin
            push(MEM_ADDR, sig(0,0,0,0,0,!s,0,0,1,0,0,0, 2'b00, 2'b10, 2'b00), 1'b0);
            if (s) begin
                push(MEM_READ, sig(0,1,0,1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00), 1'b0);
                push(MEM_WB, sig(0,0,0,0,0,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00), 1'b1);
            end else begin
                push(MEM_WRITE, sig(0,1,1,0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00), 1'b1);
            end
        end else begin
            push(BRANCH, sig(1,0,0,0,0,0,lnk,lnk,0,0,0,1, lnk ? 2'b10 : 2'b00, 2'b00, 2'b00), 1'b1);
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_strobes"}, 32'(observed_sig()), 32'd0);
        check({tag, "_done"}, 32'(instrDone), 32'd0);
        check({tag, "_retired"}, 32'(retired), 32'd0);
        check({tag, "_state"}, 32'(state_o), 32'd0);
    endtask

    // Runs one instruction; abort_at >= 0 drops reset during that cycle of the trace.
    task automatic run_instr(input string tag, input logic [3:0] c, input logic [1:0] it,
                             input logic imm, input logic [3:0] op, input logic s,
                             input logic lnk, input logic [3:0] flags, input int abort_at);
        logic [22:0] e;
        int          idx;
        bus.cond = c; bus.instType = it; bus.immBit = imm; bus.opcode = op;
        bus.sBit = s; bus.linkBit = lnk;
        {bus.ZEro, bus.carry, bus.negative, bus.overflow} = flags;
        exp_q.delete();
        build_trace(c, it, imm, op, s, lnk, flags);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (idx == abort_at) begin
                rst = 1'b0;
                @(negedge clk);
                check_quiet({tag, "_abort"});
                @(posedge clk); #1;
                rst = 1'b1;
                exp_retired = 0;
                exp_q.delete();
                break;
            end
            @(negedge clk);
            check({tag, "_state"}, 32'(state_o), 32'(e[22:19]));
            check({tag, "_strobes"}, 32'(observed_sig()), 32'(e[18:1]));
            check({tag, "_done"}, 32'(instrDone), 32'(e[0]));
            check({tag, "_retired"}, 32'(retired), 32'(exp_retired));
            if (e[0]) exp_retired = (exp_retired + 1) % (1 << RW);
            @(posedge clk); #1;
            idx++;
        end
    endtask

    initial begin
        bus.cond = '0; bus.instType = '0; bus.immBit = 1'b0; bus.opcode = '0;
        bus.sBit = 1'b0; bus.linkBit = 1'b0;
        bus.ZEro = 1'b0; bus.carry = 1'b0; bus.negative = 1'b0; bus.overflow = 1'b0;

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("reset");
            @(posedge clk); #1;
        end
        rst = 1'b1;

        //        tag        cond     type   imm  opcode   s  lnk flags  abort
        run_instr("add_al",  4'hE, 2'b00, 0, 4'b0100, 1, 0, 4'h0, -1);
        run_instr("ldr",     4'hE, 2'b01, 0, 4'b0000, 1, 0, 4'h0, -1);
        run_instr("str",     4'hE, 2'b01, 0, 4'b0000, 0, 0, 4'h0, -1);
        run_instr("bl",      4'hE, 2'b10, 0, 4'b0000, 0, 1, 4'h0, -1);
        run_instr("b",       4'hE, 2'b10, 0, 4'b0000, 0, 0, 4'h0, -1);
        run_instr("beq_nt",  4'h0, 2'b10, 0, 4'b0000, 0, 0, 4'h0, -1);
        run_instr("beq_t",   4'h0, 2'b10, 0, 4'b0000, 0, 0, 4'h8, -1);
        run_instr("cmp",     4'hE, 2'b00, 0, 4'b1010, 0, 0, 4'h0, -1);
        run_instr("and_imm", 4'hE, 2'b00, 1, 4'b0000, 1, 0, 4'h0, -1);
        run_instr("orr",     4'hE, 2'b00, 0, 4'b1100, 0, 0, 4'h0, -1);
        run_instr("sub_s",   4'hE, 2'b00, 1, 4'b0010, 1, 0, 4'h0, -1);
        run_instr("nop_op",  4'hE, 2'b00, 0, 4'b1111, 1, 0, 4'h0, -1);
        run_instr("undef",   4'hE, 2'b11, 0, 4'b0000, 0, 0, 4'h0, -1);
        run_instr("nv",      4'hF, 2'b10, 0, 4'b0000, 0, 1, 4'hF, -1);
        run_instr("ldr_rst", 4'hE, 2'b01, 0, 4'b0000, 1, 0, 4'h0, 3);
        run_instr("after_rst", 4'hE, 2'b10, 0, 4'b0000, 0, 1, 4'h0, -1);

        // HI, LS, GT, LE across every flag combination
        for (int k = 0; k < 4; k++) begin
            for (int f = 0; f < 16; f++) begin
                run_instr("cond_sweep", 4'(8 + ((k / 2) * 4) + (k % 2)), 2'b10, 0, 4'b0000,
                          0, 0, 4'(f), -1);
            end
        end

        for (int i = 0; i < 300; i++) begin
            run_instr("random", 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
